// File: rtl/nxn_game_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : nxn_game_pkg
//  Description : Shared encodings for the N x N K-in-a-row game core: cell
//                codes, winner codes, FSM states and the scan direction table.
//  Revision    : 1.0  initial release
// ============================================================================
package nxn_game_pkg;

    // Cell contents as seen on the board read port
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    // Game result codes
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Last of the four scan directions
    localparam logic [1:0] DIR_LAST = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CHECK = 1'b1
    } state_t;

    // Row delta of a scan direction: horizontal is 0, the other three step down
    function automatic logic dir_dr(input logic [1:0] dir);
        return (dir != 2'd0);
    endfunction

    // Column delta of a scan direction: (0,+1) (+1,0) (+1,+1) (+1,-1)
    function automatic logic signed [1:0] dir_dc(input logic [1:0] dir);
        logic signed [1:0] dc;
        case (dir)
            2'd0:    dc = 2'sb01;
            2'd1:    dc = 2'sb00;
            2'd2:    dc = 2'sb01;
            default: dc = 2'sb11;
        endcase
        return dc;
    endfunction

    // Board code owned by a player (0 = P1, 1 = P2)
    function automatic logic [1:0] player_cell(input logic player);
        return player ? CELL_P2 : CELL_P1;
    endfunction

endpackage : nxn_game_pkg
`default_nettype wire

// File: rtl/nxn_game_core_line_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : nxn_game_core_line_scanner
//  Description : Sequential K-in-a-row detector. Walks the four directions
//                around the last move, + ray then - ray, WIN_K-1 cells each,
//                one neighbour per cycle, accumulating run length per line.
//  Revision    : 1.0  initial release
// ============================================================================
module nxn_game_core_line_scanner
    import nxn_game_pkg::*;
#(
    parameter int BOARD_N = 3,
    parameter int WIN_K   = 3,
    parameter int IDX_W   = 4,
    parameter int RC_W    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic             start_player_i,
    input  logic [RC_W-1:0]  start_row_i,
    input  logic [RC_W-1:0]  start_col_i,
    output logic [IDX_W-1:0] cell_idx_o,
    input  logic [1:0]       cell_i,
    output logic             done_o,
    output logic             win_o
);

    // Signed coordinate width: sign bit plus one bit of headroom over the board
    localparam int CW = RC_W + 2;
    localparam int SW = $clog2(WIN_K);
    localparam int RW = $clog2(2 * WIN_K);

    localparam logic [SW-1:0]        STEP_LAST = SW'(WIN_K - 2);
    localparam logic signed [CW-1:0] N_S       = CW'(BOARD_N);
    localparam logic [RW-1:0]        K_RUN     = RW'(WIN_K);

    logic              active_q, active_d;
    logic [1:0]        dir_q,    dir_d;
    logic              side_q,   side_d;
    logic [SW-1:0]     step_q,   step_d;
    logic [RW-1:0]     run_q,    run_d;
    logic              stop_q,   stop_d;
    logic              win_q,    win_d;
    logic [RC_W-1:0]   row_q,    row_d;
    logic [RC_W-1:0]   col_q,    col_d;
    logic              player_q, player_d;

    logic signed [CW-1:0] w_off;
    logic signed [CW-1:0] w_dr_off;
    logic signed [CW-1:0] w_dc_off;
    logic signed [CW-1:0] w_nr;
    logic signed [CW-1:0] w_nc;
    logic                 w_inb;
    logic                 w_hit;
    logic                 w_last_step;
    logic                 w_last;
    logic [RW-1:0]        w_run_inc;

    // Neighbour coordinates at offset step+1 along the current ray, kept on
    // separate signed row/col values so a ray can never wrap across a row edge
    always_comb begin
        w_off    = CW'(step_q) + CW'(1);
        w_dr_off = dir_dr(dir_q) ? w_off : '0;
        case (dir_dc(dir_q))
            2'sb01:  w_dc_off = w_off;
            2'sb11:  w_dc_off = -w_off;
            default: w_dc_off = '0;
        endcase
        if (side_q) begin
            w_dr_off = -w_dr_off;
            w_dc_off = -w_dc_off;
        end
        w_nr  = $signed({2'b00, row_q}) + w_dr_off;
        w_nc  = $signed({2'b00, col_q}) + w_dc_off;
        w_inb = !w_nr[CW-1] && (w_nr < N_S) && !w_nc[CW-1] && (w_nc < N_S);
    end

    assign cell_idx_o  = IDX_W'(int'(w_nr) * BOARD_N + int'(w_nc));
    assign w_hit       = active_q && !stop_q && w_inb && (cell_i == player_cell(player_q));
    assign w_run_inc   = run_q + RW'(1);
    assign w_last_step = (step_q == STEP_LAST);
    assign w_last      = w_last_step && side_q && (dir_q == DIR_LAST);
    assign done_o      = active_q && w_last;
    assign win_o       = win_q || (w_hit && (w_run_inc >= K_RUN));

    // Scan counter sequencing and run/win accumulation
    always_comb begin
        active_d = active_q;
        dir_d    = dir_q;
        side_d   = side_q;
        step_d   = step_q;
        run_d    = run_q;
        stop_d   = stop_q;
        win_d    = win_q;
        row_d    = row_q;
        col_d    = col_q;
        player_d = player_q;
        if (clear_i) begin
            active_d = 1'b0;
            win_d    = 1'b0;
        end else if (start_i) begin
            active_d = 1'b1;
            dir_d    = 2'd0;
            side_d   = 1'b0;
            step_d   = '0;
            run_d    = RW'(1);
            stop_d   = 1'b0;
            win_d    = 1'b0;
            row_d    = start_row_i;
            col_d    = start_col_i;
            player_d = start_player_i;
        end else if (active_q) begin
            if (w_hit) begin
                run_d = w_run_inc;
            end else begin
                stop_d = 1'b1;
            end
            win_d = win_o;
            if (w_last_step) begin
                step_d = '0;
                stop_d = 1'b0;
                if (!side_q) begin
                    // Second ray of the same line keeps the run count
                    side_d = 1'b1;
                end else begin
                    side_d = 1'b0;
                    dir_d  = dir_q + 2'd1;
                    run_d  = RW'(1);
                    if (w_last) begin
                        active_d = 1'b0;
                    end
                end
            end else begin
                step_d = step_q + SW'(1);
            end
        end
    end

    // Scanner state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            dir_q    <= 2'd0;
            side_q   <= 1'b0;
            step_q   <= '0;
            run_q    <= RW'(1);
            stop_q   <= 1'b0;
            win_q    <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            player_q <= 1'b0;
        end else begin
            active_q <= active_d;
            dir_q    <= dir_d;
            side_q   <= side_d;
            step_q   <= step_d;
            run_q    <= run_d;
            stop_q   <= stop_d;
            win_q    <= win_d;
            row_q    <= row_d;
            col_q    <= col_d;
            player_q <= player_d;
        end
    end

endmodule : nxn_game_core_line_scanner
`default_nettype wire

// File: rtl/nxn_game_core.sv
`default_nettype none
// ============================================================================
//  Module      : nxn_game_core
//  Description : N x N, K-in-a-row two-player game core. Accepts moves over a
//                valid/ready handshake, enforces turn/occupancy/range, then
//                resolves win/draw with a fixed-length sequential line scan.
//  Revision    : 1.0  initial release
// ============================================================================
module nxn_game_core
    import nxn_game_pkg::*;
#(
    parameter int BOARD_N = 3,
    parameter int WIN_K   = 3,
    parameter int IDX_W   = $clog2(BOARD_N * BOARD_N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             new_game,
    input  logic             move_valid,
    input  logic             move_player,
    input  logic [IDX_W-1:0] move_idx,
    output logic             move_ready,
    output logic             move_ack,
    output logic             move_illegal,
    output logic             turn,
    output logic             over,
    output logic [1:0]       winner,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cell
);

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int RC_W  = $clog2(BOARD_N);
    localparam int CNT_W = IDX_W + 1;

    state_t           state_q,   state_d;
    logic             turn_q,    turn_d;
    logic             over_q,    over_d;
    logic [1:0]       winner_q,  winner_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             ack_q,     ack_d;
    logic             illegal_q, illegal_d;
    logic [1:0]       board_q [CELLS];

    logic             w_accept;
    logic             w_legal;
    logic [1:0]       w_mv_cell;
    logic [1:0]       w_scan_cell;
    logic [IDX_W-1:0] w_scan_idx;
    logic             w_scan_done;
    logic             w_scan_win;
    logic [RC_W-1:0]  w_row;
    logic [RC_W-1:0]  w_col;

    // Range-guarded board lookups for the display, the move target and the scanner
    always_comb begin
        rd_cell     = CELL_EMPTY;
        w_mv_cell   = CELL_EMPTY;
        w_scan_cell = CELL_EMPTY;
        if (int'(rd_idx) < CELLS)     rd_cell     = board_q[rd_idx];
        if (int'(move_idx) < CELLS)   w_mv_cell   = board_q[move_idx];
        if (int'(w_scan_idx) < CELLS) w_scan_cell = board_q[w_scan_idx];
    end

    assign w_legal = !over_q && (int'(move_idx) < CELLS) &&
                     (w_mv_cell == CELL_EMPTY) && (move_player == turn_q);
    assign w_row   = RC_W'(int'(move_idx) / BOARD_N);
    assign w_col   = RC_W'(int'(move_idx) % BOARD_N);

    // Game FSM next state: accept/reject in IDLE, resolve result at end of CHECK
    always_comb begin
        state_d   = state_q;
        turn_d    = turn_q;
        over_d    = over_q;
        winner_d  = winner_q;
        count_d   = count_q;
        ack_d     = 1'b0;
        illegal_d = 1'b0;
        w_accept  = 1'b0;
        if (new_game) begin
            state_d  = ST_IDLE;
            turn_d   = 1'b0;
            over_d   = 1'b0;
            winner_d = WIN_NONE;
            count_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (move_valid) begin
                        if (w_legal) begin
                            w_accept = 1'b1;
                            count_d  = count_q + CNT_W'(1);
                            state_d  = ST_CHECK;
                        end else begin
                            illegal_d = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (w_scan_done) begin
                        if (w_scan_win) begin
                            over_d   = 1'b1;
                            winner_d = turn_q ? WIN_P2 : WIN_P1;
                        end else if (count_q == CNT_W'(CELLS)) begin
                            over_d   = 1'b1;
                            winner_d = WIN_DRAW;
                        end
                        turn_d  = !turn_q;
                        ack_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Game control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            turn_q    <= 1'b0;
            over_q    <= 1'b0;
            winner_q  <= WIN_NONE;
            count_q   <= '0;
            ack_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            over_q    <= over_d;
            winner_q  <= winner_d;
            count_q   <= count_d;
            ack_q     <= ack_d;
            illegal_q <= illegal_d;
        end
    end

    // Board storage: cleared by reset/new_game, written on an accepted move
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CELLS; i++) board_q[i] <= CELL_EMPTY;
        end else if (new_game) begin
            for (int i = 0; i < CELLS; i++) board_q[i] <= CELL_EMPTY;
        end else if (w_accept) begin
            board_q[move_idx] <= player_cell(move_player);
        end
    end

    nxn_game_core_line_scanner #(
        .BOARD_N (BOARD_N),
        .WIN_K   (WIN_K),
        .IDX_W   (IDX_W),
        .RC_W    (RC_W)
    ) u_scanner (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear_i        (new_game),
        .start_i        (w_accept),
        .start_player_i (move_player),
        .start_row_i    (w_row),
        .start_col_i    (w_col),
        .cell_idx_o     (w_scan_idx),
        .cell_i         (w_scan_cell),
        .done_o         (w_scan_done),
        .win_o          (w_scan_win)
    );

    assign move_ready   = (state_q == ST_IDLE);
    assign move_ack     = ack_q;
    assign move_illegal = illegal_q;
    assign turn         = turn_q;
    assign over         = over_q;
    assign winner       = winner_q;

endmodule : nxn_game_core
`default_nettype wire

// File: tb/tb_nxn_game_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nxn_game_core
//  Description : Directed self-checking bench for nxn_game_core, covering a
//                3x3/K=3 instance and a 5x5/K=4 instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nxn_game_core;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       new_game;
    logic       valid;
    logic       player;
    logic [4:0] idx;
    logic [4:0] rd_idx;
    logic       sel5;

    int checks   = 0;
    int failures = 0;

    logic       ready3, ack3, ill3, turn3, over3;
    logic [1:0] win3, cell3;
    logic       ready5, ack5, ill5, turn5, over5;
    logic [1:0] win5, cell5;

    logic       ready, ack, ill, turn_o, over_o;
    logic [1:0] win_o, cell_o;

    always #5 clk = ~clk;

    nxn_game_core #(.BOARD_N(3), .WIN_K(3)) dut3 (
        .clk          (clk),
        .reset_n      (reset_n),
        .new_game     (new_game),
        .move_valid   (valid && !sel5),
        .move_player  (player),
        .move_idx     (idx[3:0]),
        .move_ready   (ready3),
        .move_ack     (ack3),
        .move_illegal (ill3),
        .turn         (turn3),
        .over         (over3),
        .winner       (win3),
        .rd_idx       (rd_idx[3:0]),
        .rd_cell      (cell3)
    );

    nxn_game_core #(.BOARD_N(5), .WIN_K(4)) dut5 (
        .clk          (clk),
        .reset_n      (reset_n),
        .new_game     (new_game),
        .move_valid   (valid && sel5),
        .move_player  (player),
        .move_idx     (idx),
        .move_ready   (ready5),
        .move_ack     (ack5),
        .move_illegal (ill5),
        .turn         (turn5),
        .over         (over5),
        .winner       (win5),
        .rd_idx       (rd_idx),
        .rd_cell      (cell5)
    );

    assign ready  = sel5 ? ready5 : ready3;
    assign ack    = sel5 ? ack5   : ack3;
    assign ill    = sel5 ? ill5   : ill3;
    assign turn_o = sel5 ? turn5  : turn3;
    assign over_o = sel5 ? over5  : over3;
    assign win_o  = sel5 ? win5   : win3;
    assign cell_o = sel5 ? cell5  : cell3;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_new_game;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    // Issue one legal move, then measure ready-low span and ack latency
    task automatic play(input logic p, input int i, input int lat_exp);
        int wait_c = 0;
        int lat    = 0;
        int low    = 0;
        while (!ready && wait_c < 100) begin
            tick();
            wait_c++;
        end
        valid  = 1'b1;
        player = p;
        idx    = 5'(i);
        tick();
        valid = 1'b0;
        while (!ack && lat < 200) begin
            if (!ready) low++;
            tick();
            lat++;
        end
        checks++;
        if (lat !== lat_exp) begin
            failures++;
            $display("FAIL ack_latency idx=%0d: got %0d cycles, expected %0d", i, lat, lat_exp);
        end
        checks++;
        if (low !== lat_exp) begin
            failures++;
            $display("FAIL ready_low idx=%0d: got %0d cycles, expected %0d", i, low, lat_exp);
        end
        tick();
        checks++;
        if (ack !== 1'b0) begin
            failures++;
            $display("FAIL ack_width idx=%0d: got %b, expected 0", i, ack);
        end
    endtask

    // Issue a request that must be rejected with a single-cycle pulse
    task automatic reject(input logic p, input int i);
        valid  = 1'b1;
        player = p;
        idx    = 5'(i);
        tick();
        valid = 1'b0;
        checks++;
        if (ill !== 1'b1 || ready !== 1'b1) begin
            failures++;
            $display("FAIL illegal_pulse p=%0d idx=%0d: got ill=%b ready=%b, expected 1 1", p, i, ill, ready);
        end
        tick();
        checks++;
        if (ill !== 1'b0) begin
            failures++;
            $display("FAIL illegal_width idx=%0d: got %b, expected 0", i, ill);
        end
    endtask

    task automatic test_reset;
        sel5 = 1'b0;
        checks++;
        if (ready !== 1'b1 || turn_o !== 1'b0 || over_o !== 1'b0 || win_o !== 2'b00 ||
            ack !== 1'b0 || ill !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy=%b turn=%b over=%b win=%b ack=%b ill=%b, expected 1 0 0 00 0 0",
                     ready, turn_o, over_o, win_o, ack, ill);
        end
        for (int c = 0; c < 9; c++) begin
            rd_idx = 5'(c);
            #1;
            checks++;
            if (cell_o !== 2'b00) begin
                failures++;
                $display("FAIL reset_cell %0d: got %b, expected 00", c, cell_o);
            end
        end
    endtask

    task automatic test_row_win;
        int seq [5] = '{0, 3, 1, 4, 2};
        sel5 = 1'b0;
        pulse_new_game();
        for (int m = 0; m < 5; m++) begin
            play(logic'(m % 2), seq[m], 16);
            if (m == 3) begin
                checks++;
                if (over_o !== 1'b0 || win_o !== 2'b00) begin
                    failures++;
                    $display("FAIL row_pre_win: got over=%b win=%b, expected 0 00", over_o, win_o);
                end
            end
        end
        rd_idx = 5'd2;
        #1;
        checks++;
        if (over_o !== 1'b1 || win_o !== 2'b01 || cell_o !== 2'b01) begin
            failures++;
            $display("FAIL row_win: got over=%b win=%b cell2=%b, expected 1 01 01", over_o, win_o, cell_o);
        end
        rd_idx = 5'd3;
        #1;
        checks++;
        if (cell_o !== 2'b10) begin
            failures++;
            $display("FAIL row_cell3: got %b, expected 10", cell_o);
        end
    endtask

    task automatic test_illegal;
        sel5 = 1'b0;
        pulse_new_game();
        play(1'b0, 4, 16);
        reject(1'b1, 4);
        rd_idx = 5'd4;
        #1;
        checks++;
        if (turn_o !== 1'b1 || cell_o !== 2'b01) begin
            failures++;
            $display("FAIL occupied_keep: got turn=%b cell4=%b, expected 1 01", turn_o, cell_o);
        end
        reject(1'b0, 0);
        reject(1'b1, 9);
        rd_idx = 5'd9;
        #1;
        checks++;
        if (cell_o !== 2'b00) begin
            failures++;
            $display("FAIL rd_out_of_range: got %b, expected 00", cell_o);
        end
        rd_idx = 5'd0;
        #1;
        checks++;
        if (cell_o !== 2'b00) begin
            failures++;
            $display("FAIL board_unchanged cell0: got %b, expected 00", cell_o);
        end
        valid  = 1'b1;
        player = 1'b1;
        idx    = 5'd4;
        tick();
        checks++;
        if (ill !== 1'b1) begin
            failures++;
            $display("FAIL repeat_illegal_1: got %b, expected 1", ill);
        end
        tick();
        valid = 1'b0;
        checks++;
        if (ill !== 1'b1) begin
            failures++;
            $display("FAIL repeat_illegal_2: got %b, expected 1", ill);
        end
        tick();
    endtask

    task automatic test_draw;
        int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        sel5 = 1'b0;
        pulse_new_game();
        for (int m = 0; m < 9; m++) begin
            play(logic'(m % 2), seq[m], 16);
        end
        checks++;
        if (over_o !== 1'b1 || win_o !== 2'b11 || turn_o !== 1'b1) begin
            failures++;
            $display("FAIL draw: got over=%b win=%b turn=%b, expected 1 11 1", over_o, win_o, turn_o);
        end
        reject(1'b1, 0);
    endtask

    task automatic test_new_game_mid_check;
        int acks = 0;
        sel5 = 1'b0;
        pulse_new_game();
        valid  = 1'b1;
        player = 1'b0;
        idx    = 5'd0;
        tick();
        valid = 1'b0;
        repeat (4) tick();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        rd_idx   = 5'd0;
        #1;
        checks++;
        if (cell_o !== 2'b00 || turn_o !== 1'b0 || ready !== 1'b1 || ack !== 1'b0) begin
            failures++;
            $display("FAIL abort_check: got cell0=%b turn=%b rdy=%b ack=%b, expected 00 0 1 0",
                     cell_o, turn_o, ready, ack);
        end
        for (int c = 0; c < 20; c++) begin
            if (ack) acks++;
            tick();
        end
        checks++;
        if (acks !== 0) begin
            failures++;
            $display("FAIL abort_no_ack: got %0d acks, expected 0", acks);
        end
        new_game = 1'b1;
        valid    = 1'b1;
        player   = 1'b0;
        idx      = 5'd4;
        tick();
        new_game = 1'b0;
        valid    = 1'b0;
        rd_idx   = 5'd4;
        #1;
        checks++;
        if (cell_o !== 2'b00 || ready !== 1'b1 || turn_o !== 1'b0) begin
            failures++;
            $display("FAIL new_game_priority: got cell4=%b rdy=%b turn=%b, expected 00 1 0",
                     cell_o, ready, turn_o);
        end
    endtask

    task automatic test_async_reset;
        sel5 = 1'b0;
        pulse_new_game();
        valid  = 1'b1;
        player = 1'b0;
        idx    = 5'd4;
        tick();
        valid  = 1'b0;
        rd_idx = 5'd4;
        repeat (3) tick();
        checks++;
        if (ready !== 1'b0 || cell_o !== 2'b01) begin
            failures++;
            $display("FAIL pre_reset_busy: got rdy=%b cell4=%b, expected 0 01", ready, cell_o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || cell_o !== 2'b00 || turn_o !== 1'b0 || ack !== 1'b0 ||
            over_o !== 1'b0 || win_o !== 2'b00) begin
            failures++;
            $display("FAIL async_reset: got rdy=%b cell4=%b turn=%b ack=%b over=%b win=%b, expected 1 00 0 0 0 00",
                     ready, cell_o, turn_o, ack, over_o, win_o);
        end
        #3;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_edge_wrap;
        int seq_a [7] = '{3, 24, 4, 22, 5, 14, 6};
        int seq_b [6] = '{10, 7, 17, 11, 9, 15};
        sel5 = 1'b1;
        pulse_new_game();
        for (int m = 0; m < 7; m++) begin
            play(logic'(m % 2), seq_a[m], 24);
        end
        checks++;
        if (over_o !== 1'b0 || win_o !== 2'b00) begin
            failures++;
            $display("FAIL edge_no_wrap: got over=%b win=%b, expected 0 00", over_o, win_o);
        end
        for (int m = 0; m < 6; m++) begin
            play(logic'((m + 1) % 2), seq_b[m], 24);
        end
        rd_idx = 5'd15;
        #1;
        checks++;
        if (over_o !== 1'b1 || win_o !== 2'b01 || cell_o !== 2'b01) begin
            failures++;
            $display("FAIL anti_diag_win: got over=%b win=%b cell15=%b, expected 1 01 01", over_o, win_o, cell_o);
        end
        sel5 = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        new_game = 1'b0;
        valid    = 1'b0;
        player   = 1'b0;
        idx      = '0;
        rd_idx   = '0;
        sel5     = 1'b0;
        #23;
        test_reset();
        reset_n = 1'b1;
        tick();
        test_row_win();
        test_illegal();
        test_draw();
        test_new_game_mid_check();
        test_async_reset();
        test_edge_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nxn_game_core
`default_nettype wire
